pragmatic_term_scheduler: RTL and testbench

Upstream control stage for the 16-lane Pragmatic MAC. It accepts a vector of 16 signed 8-bit weights, recodes each weight into non-adjacent-form (NAF) signed power-of-two terms, and issues one term per lane per beat. Each beat drives the MAC's per-lane first-stage shift/enable/negate controls and the shared second-stage shift. It also produces first/last beat markers, which the controller uses for `load_accum` and result hand-off.

---
 rtl/pragmatic_term_scheduler.sv | 146 ++++++++++++++
 tb/tb_pragmatic_term_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pragmatic_term_scheduler.sv
// pragmatic_term_scheduler: recodes a vector of signed weights into NAF
// signed power-of-two terms and issues, per beat, one term per lane within
// a 4-position window above the shared base position.
module pragmatic_term_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16,
  localparam int PW = $clog2(DATA_WIDTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH*VEC_LENGTH-1:0] w_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [2*VEC_LENGTH-1:0]          shift_1st_sel,
  output logic [VEC_LENGTH-1:0]            shift_1st_en,
  output logic [VEC_LENGTH-1:0]            is_neg,
  output logic [PW-1:0]                    shift_2nd_sel,
  output logic                             shift_2nd_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_first,
  output logic                             out_last
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic [DATA_WIDTH*VEC_LENGTH-1:0] pos_q, neg_q;
  logic                             first_q;

  logic [DATA_WIDTH*VEC_LENGTH-1:0] naf_pos, naf_neg, pos_clr;
  logic [PW-1:0]                    low_idx [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]            lane_nz;
  logic [PW-1:0]                    base;
  logic [PW-1:0]                    lane_off;
  logic                             any_term;
  logic [VEC_LENGTH-1:0]            issue_en, issue_neg;
  logic [2*VEC_LENGTH-1:0]          issue_sel;
  logic                             beat_last;
  logic                             busy, load, fire;

  // NAF recoding of each lane: recode |w|, then flip digit signs for negative w.
  for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_naf
    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH:0]   ext, mag, xh, x3, c, np, nm;
    logic                  unused_hi;
    assign w   = w_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign ext = {w[DATA_WIDTH-1], w};
    assign mag = w[DATA_WIDTH-1] ? (~ext + 1'b1) : ext;
    assign xh  = mag >> 1;
    assign x3  = mag + xh;
    assign c   = xh ^ x3;
    assign np  = x3 & c;
    assign nm  = xh & c;
    // The top digit is always zero for magnitudes up to 2^(DATA_WIDTH-1).
    assign unused_hi = np[DATA_WIDTH] | nm[DATA_WIDTH];
    assign naf_pos[gi*DATA_WIDTH +: DATA_WIDTH] = np[DATA_WIDTH-1:0] | nm[DATA_WIDTH-1:0];
    assign naf_neg[gi*DATA_WIDTH +: DATA_WIDTH] =
      w[DATA_WIDTH-1] ? np[DATA_WIDTH-1:0] : nm[DATA_WIDTH-1:0];
  end

  assign busy = (state_q == BUSY);
  assign fire = busy && out_ready;
  assign load = in_valid && in_ready;

  // Lowest pending digit per lane and the shared base (min over non-empty lanes).
  always_comb begin
    any_term = 1'b0;
    base     = '1;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      low_idx[j] = '0;
      for (int b = DATA_WIDTH - 1; b >= 0; b--) begin
        if (pos_q[j*DATA_WIDTH + b]) low_idx[j] = PW'(b);
      end
      lane_nz[j] = |pos_q[j*DATA_WIDTH +: DATA_WIDTH];
      if (lane_nz[j] && (low_idx[j] < base)) base = low_idx[j];
      any_term = any_term | lane_nz[j];
    end
    if (!any_term) base = '0;
  end

  // Lanes within base..base+3 issue their lowest digit; compute the post-beat masks.
  always_comb begin
    issue_en  = '0;
    issue_neg = '0;
    issue_sel = '0;
    pos_clr   = pos_q;
    lane_off  = '0;
    for (int j = 0; j < VEC_LENGTH; j++) begin
      lane_off = low_idx[j] - base;
      if (lane_nz[j] && ({1'b0, low_idx[j]} <= ({1'b0, base} + (PW+1)'(3)))) begin
        issue_en[j]       = 1'b1;
        issue_sel[2*j +: 2] = lane_off[1:0];
        issue_neg[j]      = neg_q[j*DATA_WIDTH + int'(low_idx[j])];
        pos_clr[j*DATA_WIDTH + int'(low_idx[j])] = 1'b0;
      end
    end
    beat_last = ~|pos_clr;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: stay busy across the last beat only when a new vector is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = BUSY;
      BUSY:    if (fire && beat_last) state_d = load ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: beat fields are driven only while busy so idle shows all zeros.
  always_comb begin
    out_valid     = busy;
    in_ready      = !busy || (out_ready && beat_last);
    shift_1st_en  = busy ? issue_en  : '0;
    shift_1st_sel = busy ? issue_sel : '0;
    is_neg        = busy ? issue_neg : '0;
    shift_2nd_sel = busy ? base      : '0;
    shift_2nd_en  = busy && any_term;
    out_first     = busy && first_q;
    out_last      = busy && beat_last;
  end

  // Digit masks: load a fresh NAF, or retire the issued digits on a consumed beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q   <= '0;
      neg_q   <= '0;
      first_q <= 1'b0;
    end else if (load) begin
      pos_q   <= naf_pos;
      neg_q   <= naf_neg;
      first_q <= 1'b1;
    end else if (fire) begin
      pos_q   <= pos_clr;
      first_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pragmatic_term_scheduler.sv
// Directed testbench for pragmatic_term_scheduler: each task drives one
// scenario and compares the full beat (valid/first/last/shift/en/neg) against
// hand-computed values.
module tb_pragmatic_term_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] w_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  shift_1st_sel;
  logic [15:0]  shift_1st_en;
  logic [15:0]  is_neg;
  logic [2:0]   shift_2nd_sel;
  logic         shift_2nd_en;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_first;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  logic [70:0] obs;
  logic [70:0] exp_v;

  pragmatic_term_scheduler dut (
    .clk(clk), .reset(reset), .w_in(w_in), .in_valid(in_valid), .in_ready(in_ready),
    .shift_1st_sel(shift_1st_sel), .shift_1st_en(shift_1st_en), .is_neg(is_neg),
    .shift_2nd_sel(shift_2nd_sel), .shift_2nd_en(shift_2nd_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  assign obs = {out_valid, out_first, out_last, shift_2nd_en, shift_2nd_sel,
                shift_1st_en, shift_1st_sel, is_neg};

  function automatic logic [70:0] mk(input logic v, input logic f, input logic l,
                                     input logic e2, input logic [2:0] s2,
                                     input logic [15:0] e1, input logic [31:0] s1,
                                     input logic [15:0] ng);
    return {v, f, l, e2, s2, e1, s1, ng};
  endfunction

  // Present a vector from a negedge, wait (bounded) for acceptance; returns at
  // the negedge where the first beat is visible.
  task automatic load_vec(input logic [127:0] w, input string name);
    int n = 0;
    @(negedge clk);
    w_in = w;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: in_ready got %b expected 1 (timeout)", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    $display("load %s w=%h", name, w);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 71'h0);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    reset = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_all_ones();
    load_vec({16{8'h01}}, "all_ones");
    exp_v = mk(1, 1, 1, 1, 3'd0, 16'hFFFF, 32'h0, 16'h0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL all_ones beat: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    checks++;
    if (obs !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL all_ones idle: got %h rdy %b expected %h rdy 1", obs, in_ready, 71'h0);
    end
    $display("all_ones done");
  endtask

  task automatic test_naf107();
    logic [2:0] bases [4] = '{3'd0, 3'd2, 3'd4, 3'd7};
    logic [3:0] negs = 4'b0111;
    load_vec({120'h0, 8'd107}, "naf107");
    for (int b = 0; b < 4; b++) begin
      exp_v = mk(1, b == 0, b == 3, 1, bases[b], 16'h0001, 32'h0, {15'h0, negs[b]});
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL naf107 beat%0d: got %h expected %h", b, obs, exp_v);
      end
      $display("naf107 beat%0d base=%0d", b, shift_2nd_sel);
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL naf107 idle: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_window();
    load_vec({104'h0, 8'd16, 8'd8, 8'd1}, "window");
    exp_v = mk(1, 1, 0, 1, 3'd0, 16'h0003, 32'h0000_000C, 16'h0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL window beat0: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = mk(1, 0, 1, 1, 3'd4, 16'h0004, 32'h0, 16'h0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL window beat1: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    $display("window done");
  endtask

  task automatic test_neg128_and_zero();
    load_vec({16{8'h80}}, "neg128");
    exp_v = mk(1, 1, 1, 1, 3'd7, 16'hFFFF, 32'h0, 16'hFFFF);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL neg128 beat: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    load_vec(128'h0, "zero");
    exp_v = mk(1, 1, 1, 0, 3'd0, 16'h0, 32'h0, 16'h0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero beat: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero idle: out_valid got %b expected 0", out_valid);
    end
    $display("neg128/zero done");
  endtask

  task automatic test_back_to_back();
    logic [70:0] beat1;
    load_vec({120'h0, 8'd107}, "bp107");
    @(negedge clk);
    beat1 = mk(1, 0, 0, 1, 3'd2, 16'h0001, 32'h0, 16'h0001);
    out_ready = 1'b0;
    w_in = {16{8'h01}};
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs !== beat1) begin
        errors++;
        $display("FAIL stall%0d frozen: got %h expected %h", k, obs, beat1);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d in_ready: got %b expected 0", k, in_ready);
      end
      $display("stall cycle %0d", k);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    exp_v = mk(1, 0, 0, 1, 3'd4, 16'h0001, 32'h0, 16'h0001);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL bp beat2: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    exp_v = mk(1, 0, 1, 1, 3'd7, 16'h0001, 32'h0, 16'h0);
    checks++;
    if (obs !== exp_v || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp last: got %h rdy %b expected %h rdy 1", obs, in_ready, exp_v);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exp_v = mk(1, 1, 1, 1, 3'd0, 16'hFFFF, 32'h0, 16'h0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL b2b first: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    $display("back_to_back done");
  endtask

  task automatic test_reset_mid();
    load_vec({120'h0, 8'd107}, "rst107");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (obs !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got %h rdy %b expected %h rdy 1", obs, in_ready, 71'h0);
    end
    load_vec({16{8'h01}}, "after_rst");
    exp_v = mk(1, 1, 1, 1, 3'd0, 16'hFFFF, 32'h0, 16'h0);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL after_reset first: got %h expected %h", obs, exp_v);
    end
    @(negedge clk);
    $display("reset_mid done");
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_naf107();
    test_window();
    test_neg128_and_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
